// File: rtl/aquarium_pump_sequencer.sv
// aquarium_pump_sequencer: safe hot/cold pump driver with min on/off times and a max-run fault.
// Optional PUMP_RUNTIME_STATS_EN builds per-pump run-tick counters (else hot_ticks/cold_ticks read 0).
module aquarium_pump_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int MIN_ON   = 5,
  parameter int MIN_OFF  = 3,
  parameter int MAX_RUN  = 600,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_hot,
  input  logic        req_cold,
  input  logic        fault_clr,
  output logic        pump_hot,
  output logic        pump_cold,
  output logic        conflict,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] hot_ticks,
  output logic [15:0] cold_ticks
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, RUN_HOT = 3'd1, RUN_COLD = 3'd2, COOLDOWN = 3'd3, FAULT = 3'd4} state_t;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, off_cnt_q, off_cnt_d;
  logic             pump_hot_q, pump_cold_q, conflict_q, fault_q;
  logic             tick, valid_hot, valid_cold, own_req, running, changed;
  always_comb begin
    tick       = div_q == DIV_W'(TICK_DIV - 1);
    valid_hot  = req_hot & ~req_cold;
    valid_cold = req_cold & ~req_hot;
    running    = (state_q == RUN_HOT) || (state_q == RUN_COLD);
    own_req    = (state_q == RUN_HOT) ? valid_hot : valid_cold;
    state_d    = state_q;
    case (state_q)
      IDLE:              state_d = valid_hot ? RUN_HOT : valid_cold ? RUN_COLD : IDLE;
      RUN_HOT, RUN_COLD: state_d = (run_cnt_q == CNT_W'(MAX_RUN)) ? FAULT :
                                   (!own_req && run_cnt_q >= CNT_W'(MIN_ON)) ? COOLDOWN : state_q;
      COOLDOWN:          state_d = (off_cnt_q == CNT_W'(MIN_OFF)) ? IDLE : COOLDOWN;
      FAULT:             state_d = (fault_clr && !req_hot && !req_cold) ? COOLDOWN : FAULT;
      default:           state_d = IDLE;
    endcase
    changed   = state_d != state_q;
    div_d     = (changed || tick) ? '0 : div_q + 1'b1;
    run_cnt_d = changed ? '0 : (tick && running && run_cnt_q != CNT_W'(MAX_RUN)) ? run_cnt_q + 1'b1 : run_cnt_q;
    off_cnt_d = changed ? '0 : (tick && state_q == COOLDOWN) ? off_cnt_q + 1'b1 : off_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      run_cnt_q   <= '0;
      off_cnt_q   <= '0;
      pump_hot_q  <= 1'b0;
      pump_cold_q <= 1'b0;
      conflict_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      run_cnt_q   <= run_cnt_d;
      off_cnt_q   <= off_cnt_d;
      pump_hot_q  <= state_d == RUN_HOT;
      pump_cold_q <= state_d == RUN_COLD;
      conflict_q  <= req_hot & req_cold;
      fault_q     <= state_d == FAULT;
    end
  end
  assign pump_hot  = pump_hot_q;
  assign pump_cold = pump_cold_q;
  assign conflict  = conflict_q;
  assign fault     = fault_q;
  assign state     = state_q;
`ifdef PUMP_RUNTIME_STATS_EN
  logic [15:0] hot_ticks_q, hot_ticks_d, cold_ticks_q, cold_ticks_d;
  always_comb begin
    hot_ticks_d  = (tick && state_q == RUN_HOT && hot_ticks_q != 16'hFFFF) ? hot_ticks_q + 1'b1 : hot_ticks_q;
    cold_ticks_d = (tick && state_q == RUN_COLD && cold_ticks_q != 16'hFFFF) ? cold_ticks_q + 1'b1 : cold_ticks_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hot_ticks_q  <= '0;
      cold_ticks_q <= '0;
    end else begin
      hot_ticks_q  <= hot_ticks_d;
      cold_ticks_q <= cold_ticks_d;
    end
  end
  assign hot_ticks  = hot_ticks_q;
  assign cold_ticks = cold_ticks_q;
`else
  assign hot_ticks  = '0;
  assign cold_ticks = '0;
`endif
endmodule
